// File: rtl/mult_tile_pkg.sv
// Shared constants and types for the tile-iterating 8x8 multiplier.
//   WIDTH   : operand width
//   DIGIT   : tile operand width
//   NDIG    : digits per operand
//   ACC_W   : accumulator width (17 bits worst case, plus one bit of margin)
//   state_t : control FSM states
package mult_tile_pkg;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DIGIT   = 2;
  localparam int unsigned NDIG    = WIDTH / DIGIT;
  localparam int unsigned ACC_W   = 18;
  localparam int unsigned IDX_W   = $clog2(NDIG);
  localparam int unsigned CNT_W   = 2 * IDX_W;
  localparam int unsigned SHIFT_W = $clog2(2 * DIGIT * (NDIG - 1) + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mult8_tile_seq_if.sv
// Operand/result handshake bundle for mult8_tile_seq.
//   in_valid/in_ready/a/b       : operand pair handshake
//   out_valid/out_ready/p/ovf   : result handshake
//   master : producer of operands / consumer of results
//   slave  : the multiplier
interface mult8_tile_seq_if;
  import mult_tile_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;
  logic                 ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, ovf
  );
endinterface

// File: rtl/mult8_digit_seq.sv
// Digit-pair sequencer: 4-bit counter walking all digit pairs, a digit outer
// (i = upper bits), b digit inner (j = lower bits).
//   clk, rst : clock, synchronous active-high reset
//   start    : clear the counter (operand accept)
//   run      : advance one pair per cycle
//   i, j     : current a / b digit index
//   shift    : weight of the current partial product, DIGIT*(i+j)
//   last     : final pair is being presented
module mult8_digit_seq
  import mult_tile_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               run,
  output logic [IDX_W-1:0]   i,
  output logic [IDX_W-1:0]   j,
  output logic [SHIFT_W-1:0] shift,
  output logic               last
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    i     = cnt[CNT_W-1 -: IDX_W];
    j     = cnt[IDX_W-1:0];
    shift = SHIFT_W'(DIGIT * (int'(i) + int'(j)));
    last  = &cnt;
  end
endmodule

// File: rtl/mult8_tile_seq.sv
// Sequential 8x8 unsigned multiplier driving an external 2x2 tile multiplier
// over all 16 digit pairs and shift-accumulating its products.
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : operand handshake (in_valid/in_ready/a/b) and result
//                    handshake (out_valid/out_ready/p/ovf)
//   tile_a, tile_b : digits presented to the tile (0 outside RUN)
//   tile_p         : combinational tile product
//   err_abs        : |acc - a*b|, present only with MULT8_ERR_MON_EN defined
module mult8_tile_seq
  import mult_tile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mult8_tile_seq_if.slave      bus,
  output logic [DIGIT-1:0]     tile_a,
  output logic [DIGIT-1:0]     tile_b,
  input  logic [2*DIGIT-1:0]   tile_p
`ifdef MULT8_ERR_MON_EN
  ,
  output logic [2*WIDTH:0]     err_abs
`endif
);
  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [ACC_W-1:0]   acc;
  logic               out_valid_q;
  logic               accept;
  logic               run;
  logic [IDX_W-1:0]   di;
  logic [IDX_W-1:0]   dj;
  logic [SHIFT_W-1:0] shift;
  logic               last;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign run           = (state == RUN);
  assign bus.out_valid = out_valid_q;
  assign bus.p         = acc[2*WIDTH-1:0];
  assign bus.ovf       = |acc[ACC_W-1:2*WIDTH];

  mult8_digit_seq u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .run   (run),
    .i     (di),
    .j     (dj),
    .shift (shift),
    .last  (last)
  );

  always_comb begin
    tile_a = '0;
    tile_b = '0;
    if (run) begin
      tile_a = a_reg[int'(di)*DIGIT +: DIGIT];
      tile_b = b_reg[int'(dj)*DIGIT +: DIGIT];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            acc   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc + (ACC_W'(tile_p) << shift);
          if (last) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULT8_ERR_MON_EN
  // Reference product from the latched operands; a_reg/b_reg clear on reset,
  // so err_abs is 0 after reset and stable in DONE.
  logic [2*WIDTH-1:0] exact;
  logic [ACC_W-1:0]   exact_ext;
  logic [ACC_W-1:0]   diff;

  always_comb begin
    exact     = a_reg * b_reg;
    exact_ext = ACC_W'(exact);
    diff      = (acc >= exact_ext) ? (acc - exact_ext) : (exact_ext - acc);
    err_abs   = (2*WIDTH+1)'(diff);
  end
`endif
endmodule
